// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters and
// sequences the start/busy/complete handshake; UART_TX_ARB_TIMEOUT_EN adds a START ack timeout.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ACK_TIMEOUT = 65535
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic                 err,
   output logic [7:0]           THR,
   output logic                 tx_en,
   input  logic                 tx_status
);

   // state   | meaning
   // IDLE    | transmitter idle, pick next requester round-robin from ptr
   // START   | tx_en high, waiting for the transmitter to report busy
   // WAIT    | transmitter busy shifting the byte out
   // RELEASE | one cycle: done pulse to the winner, ptr moves past it

   localparam int unsigned PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PW1 = PW + 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || ACK_TIMEOUT < 1) begin : g_bad_param
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and ACK_TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 ts_meta_q, ts_s_q;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        win_q, win_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [7:0]           thr_q, thr_d;
   logic                 tx_en_q, tx_en_d;
   logic                 timeout;
   logic                 to_flag;

   logic                 found;
   logic [PW-1:0]        pick;
   logic [PW1-1:0]       cand;

   // Search order ptr, ptr+1, ... with an explicit wrap since NUM_REQ need not be 2^n.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + PW1'(i);
         if (cand >= PW1'(NUM_REQ)) begin
            cand = cand - PW1'(NUM_REQ);
         end
         if (!found && req[cand[PW-1:0]]) begin
            found = 1'b1;
            pick  = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         ts_meta_q <= 1'b0;
         ts_s_q    <= 1'b0;
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         gnt_q     <= '0;
         thr_q     <= 8'h00;
         tx_en_q   <= 1'b0;
      end else begin
         ts_meta_q <= tx_status;
         ts_s_q    <= ts_meta_q;
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         gnt_q     <= gnt_d;
         thr_q     <= thr_d;
         tx_en_q   <= tx_en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      gnt_d   = gnt_q;
      thr_d   = thr_q;
      tx_en_d = tx_en_q;
      case (state_q)
         ST_IDLE: begin
            if (!ts_s_q && found) begin
               win_d   = pick;
               gnt_d   = NUM_REQ'(1) << pick;
               thr_d   = req_data[8*pick +: 8];
               tx_en_d = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (ts_s_q) begin
               tx_en_d = 1'b0;
               state_d = ST_WAIT;
            end else if (timeout) begin
               tx_en_d = 1'b0;
               state_d = ST_RELEASE;
            end
         end
         ST_WAIT: begin
            if (!ts_s_q) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            gnt_d   = '0;
            ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          to_q, to_d;

   // Down-counter loaded on the grant edge; terminal count means ACK_TIMEOUT START cycles elapsed.
   always_comb begin
      tmr_d = tmr_q;
      to_d  = to_q;
      if (state_q == ST_IDLE && state_d == ST_START) begin
         tmr_d = TW'(ACK_TIMEOUT - 1);
         to_d  = 1'b0;
      end else if (state_q == ST_START) begin
         if (timeout && !ts_s_q) begin
            to_d = 1'b1;
         end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         tmr_q <= '0;
         to_q  <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         to_q  <= to_d;
      end
   end

   assign timeout = (tmr_q == '0);
   assign to_flag = to_q;
`else
   assign timeout = 1'b0;
   assign to_flag = 1'b0;
`endif

   always_comb begin
      gnt   = gnt_q;
      THR   = thr_q;
      tx_en = tx_en_q;
      done  = '0;
      err   = 1'b0;
      if (state_q == ST_RELEASE) begin
         done = NUM_REQ'(1) << win_q;
         err  = to_flag;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a transaction-level
// round-robin model; the timeout section is compiled when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

   localparam int N      = 4;
   localparam int ACK_TO = 16;

   logic             sys_clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*8-1:0]   req_data = '0;
   logic [N-1:0]     gnt, done;
   logic             err;
   logic [7:0]       THR;
   logic             tx_en;
   logic             tx_status = 1'b0;

   int               n_checks = 0;
   int               n_errors = 0;
   int               ptr_m = 0;
   int               age [N];
   logic [7:0]       exp_thr;

   uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(ACK_TO)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .THR       (THR),
      .tx_en     (tx_en),
      .tx_status (tx_status)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Reference arbitration: first requester at or after ptr, modulo N.
   function automatic int pick_m(input logic [N-1:0] m, input int p);
      for (int i = 0; i < N; i++) begin
         if (m[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic do_reset();
      req       = '0;
      tx_status = 1'b0;
      rst       = 1'b0;
      tick();
      tick();
      rst   = 1'b1;
      ptr_m = 0;
      for (int i = 0; i < N; i++) age[i] = 0;
   endtask

   task automatic await_grant(output int w, output int lat);
      int k = 0;
      w = pick_m(req, ptr_m);
      lat = 0;
      if (w < 0) begin
         chk("model_has_request", 0, 1);
         w = 0;
         return;
      end
      exp_thr = req_data[8*w +: 8];
      do begin
         tick();
         k++;
      end while (gnt == '0 && k < 40);
      lat = k;
      chk("grant_seen", (gnt != '0), 1);
      chk("gnt", gnt, 1 << w);
      chk("thr", THR, exp_thr);
      chk("tx_en_set", tx_en, 1);
      for (int i = 0; i < N; i++) begin
         if (req[i] && i != w) age[i]++;
      end
      chk("fair_wait", (age[w] < N), 1);
      age[w] = 0;
   endtask

   task automatic serve(input int w, input int dly, input int blen,
                        input logic [N-1:0] nreq, input logic [N*8-1:0] ndata);
      repeat (dly) tick();
      chk("tx_en_start", tx_en, 1);
      tx_status = 1'b1;
      tick();
      tick();
      chk("tx_en_sync", tx_en, 1);
      tick();
      chk("tx_en_fall", tx_en, 0);
      repeat (blen) tick();
      chk("thr_held", THR, exp_thr);
      chk("gnt_held", gnt, 1 << w);
      tx_status = 1'b0;
      tick();
      tick();
      chk("done_early", done, 0);
      tick();
      chk("done", done, 1 << w);
      chk("err", err, 0);
      ptr_m    = (w + 1) % N;
      req      = nreq;
      req_data = ndata;
      tick();
      chk("done_pulse", done, 0);
      chk("gnt_clear", gnt, 0);
   endtask

   int rr_exp   [5] = '{0, 1, 2, 3, 0};
   int fair_exp [4] = '{0, 2, 0, 2};

   initial begin
      int w, lat, k;
      logic [N-1:0]   nreq, add;
      logic [N*8-1:0] nd;

      for (int i = 0; i < N; i++) age[i] = 0;

      // reset with arbitrary requests
      req      = N'($urandom_range(1, (1 << N) - 1));
      req_data = {$urandom, $urandom};
      tx_status = 1'b0;
      repeat (3) tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_thr", THR, 8'h00);
      chk("rst_tx_en", tx_en, 0);

      // first transfer after reset
      req = '0;
      rst = 1'b1;
      req = 4'b0001;
      req_data[7:0] = 8'hA5;
      await_grant(w, lat);
      chk("grant_latency", lat, 1);
      chk("first_thr", THR, 8'hA5);
      serve(w, 0, 20, '0, req_data);

      // round robin with all requesters pending
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
      for (int i = 0; i < 5; i++) begin
         await_grant(w, lat);
         chk("rr_gnt", gnt, 1 << rr_exp[i]);
         chk("rr_thr", THR, 8'h10 + 8'(rr_exp[i]));
         serve(w, 1, 3, 4'b1111, req_data);
      end

      // fairness: requester 0 re-requests right after its done
      do_reset();
      req = 4'b0101;
      req_data = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         await_grant(w, lat);
         chk("fair_gnt", gnt, 1 << fair_exp[i]);
         serve(w, $urandom_range(0, 3), $urandom_range(1, 5),
               (i == 3) ? 4'b0000 : 4'b0101, req_data);
      end

      // busy at idle: no grant while the transmitter reports busy
      tick();
      tx_status = 1'b1;
      repeat (3) tick();
      req = 4'b0010;
      req_data[15:8] = 8'h5C;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("busy_no_gnt", gnt, 0);
      end
      tx_status = 1'b0;
      tick();
      tick();
      chk("busy_gnt_early", gnt, 0);
      tick();
      chk("busy_gnt", gnt, 4'b0010);
      chk("busy_thr", THR, 8'h5C);
      exp_thr = 8'h5C;
      serve(1, 0, 4, 4'b0100, req_data);

      // reset during WAIT
      await_grant(w, lat);
      tx_status = 1'b1;
      repeat (4) tick();
      req = '0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_tx_en", tx_en, 0);
      chk("mid_rst_thr", THR, 8'h00);
      chk("mid_rst_done", done, 0);
      tick();
      tick();
      rst   = 1'b1;
      ptr_m = 0;
      for (int i = 0; i < N; i++) age[i] = 0;
      repeat (3) tick();
      req = 4'b0001;
      req_data[7:0] = 8'h3E;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_no_gnt", gnt, 0);
      end
      tx_status = 1'b0;
      await_grant(w, lat);
      chk("post_rst_lat", lat, 3);
      serve(w, 2, 2, '0, req_data);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // START timeout with the transmitter never answering
      do_reset();
      req = 4'b1000;
      req_data[31:24] = 8'hC3;
      await_grant(w, lat);
      chk("to_winner", w, 3);
      k = 0;
      while (tx_en && k < 40) begin
         tick();
         k++;
      end
      chk("to_cycles", k, ACK_TO);
      chk("to_done", done, 4'b1000);
      chk("to_err", err, 1);
      ptr_m = 0;
      req = 4'b1111;
      tick();
      chk("to_done_pulse", done, 0);
      chk("to_err_pulse", err, 0);
      await_grant(w, lat);
      chk("to_ptr_wrap", gnt, 4'b0001);
      serve(w, 1, 2, '0, req_data);
`endif

      // randomized traffic against the model
      do_reset();
      req      = N'($urandom_range(1, (1 << N) - 1));
      req_data = {$urandom, $urandom};
      for (int r = 0; r < 40; r++) begin
         await_grant(w, lat);
         nreq = req & ~(N'(1) << w);
         nd   = req_data;
         add  = N'($urandom_range(0, (1 << N) - 1));
         if ((nreq | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (add[i] && !nreq[i]) begin
               nreq[i]        = 1'b1;
               nd[8*i +: 8]   = 8'($urandom);
            end
         end
         serve(w, $urandom_range(0, 4), $urandom_range(1, 6), nreq, nd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
